// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-ported data memory: per-beat grant with
// ownership and a bounded hold, plus a one-deep tag steering read returns.
module dmem_arbiter #(
    parameter int ADDR_W   = 8,
    parameter int DATA_W   = 64,
    parameter int HOLD_MAX = 4
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              C_Req,
    input  logic              C_WrEn,
    input  logic [ADDR_W-1:0] C_Addr,
    input  logic [DATA_W-1:0] C_WrData,
    output logic              C_Gnt,
    output logic              C_RdVld,
    input  logic              N_Req,
    input  logic              N_WrEn,
    input  logic [ADDR_W-1:0] N_Addr,
    input  logic [DATA_W-1:0] N_WrData,
    output logic              N_Gnt,
    output logic              N_RdVld,
    output logic [DATA_W-1:0] Rd_Data,
    output logic [ADDR_W-1:0] Mem_Addr,
    output logic [DATA_W-1:0] Mem_WrData,
    output logic              DmemEn,
    output logic              DmemWrEn,
    input  logic [DATA_W-1:0] Mem_RdData
);

    typedef enum logic [1:0] {IDLE, C_OWN, N_OWN} state_t;

    localparam int CNT_W = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             last_n_q, last_n_d;   // 1: N was the last owner
    logic             tag_vld_q, tag_vld_d;
    logic             tag_n_q, tag_n_d;
    logic             c_gnt, n_gnt;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        last_n_d = last_n_q;
        c_gnt    = 1'b0;
        n_gnt    = 1'b0;
        case (state_q)
            IDLE: begin
                if (C_Req && (!N_Req || last_n_q)) begin
                    c_gnt   = 1'b1;
                    state_d = C_OWN;
                    cnt_d   = '0;
                end else if (N_Req) begin
                    n_gnt   = 1'b1;
                    state_d = N_OWN;
                    cnt_d   = '0;
                end
            end
            C_OWN: begin
                // cnt counts beats C kept the port while N was waiting
                if (C_Req && (!N_Req || cnt_q != CNT_LAST)) begin
                    c_gnt = 1'b1;
                    cnt_d = N_Req ? cnt_q + CNT_W'(1) : '0;
                end else if (N_Req) begin
                    n_gnt    = 1'b1;
                    state_d  = N_OWN;
                    cnt_d    = '0;
                    last_n_d = 1'b0;
                end else begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    last_n_d = 1'b0;
                end
            end
            N_OWN: begin
                if (N_Req && (!C_Req || cnt_q != CNT_LAST)) begin
                    n_gnt = 1'b1;
                    cnt_d = C_Req ? cnt_q + CNT_W'(1) : '0;
                end else if (C_Req) begin
                    c_gnt    = 1'b1;
                    state_d  = C_OWN;
                    cnt_d    = '0;
                    last_n_d = 1'b1;
                end else begin
                    state_d  = IDLE;
                    cnt_d    = '0;
                    last_n_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        // Nothing is granted while reset is held, whatever the request levels.
        if (Reset) begin
            c_gnt = 1'b0;
            n_gnt = 1'b0;
        end
        tag_vld_d = (c_gnt && !C_WrEn) || (n_gnt && !N_WrEn);
        tag_n_d   = n_gnt;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            last_n_q  <= 1'b1;
            tag_vld_q <= 1'b0;
            tag_n_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_n_q  <= last_n_d;
            tag_vld_q <= tag_vld_d;
            tag_n_q   <= tag_n_d;
        end
    end

    assign C_Gnt      = c_gnt;
    assign N_Gnt      = n_gnt;
    assign DmemEn     = c_gnt | n_gnt;
    assign DmemWrEn   = (c_gnt & C_WrEn) | (n_gnt & N_WrEn);
    assign Mem_Addr   = c_gnt ? C_Addr   : (n_gnt ? N_Addr   : '0);
    assign Mem_WrData = c_gnt ? C_WrData : (n_gnt ? N_WrData : '0);

    // A return that lands on a reset cycle is suppressed along with everything else.
    assign C_RdVld = !Reset && tag_vld_q && !tag_n_q;
    assign N_RdVld = !Reset && tag_vld_q &&  tag_n_q;
    assign Rd_Data = (!Reset && tag_vld_q) ? Mem_RdData : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized bench for dmem_arbiter: ownership/hold model, per-cycle compare,
// and a few directed scenarios with literal expectations.
module tb_dmem_arbiter;

    localparam int HOLD_MAX = 4;

    logic        Clock = 1'b0;
    logic        Reset;
    logic        C_Req, C_WrEn, N_Req, N_WrEn;
    logic [7:0]  C_Addr, N_Addr;
    logic [63:0] C_WrData, N_WrData, Mem_RdData;
    logic        C_Gnt, C_RdVld, N_Gnt, N_RdVld, DmemEn, DmemWrEn;
    logic [63:0] Rd_Data, Mem_WrData;
    logic [7:0]  Mem_Addr;

    int checks = 0;
    int failures = 0;

    dmem_arbiter #(.ADDR_W(8), .DATA_W(64), .HOLD_MAX(HOLD_MAX)) dut (
        .Clock(Clock), .Reset(Reset),
        .C_Req(C_Req), .C_WrEn(C_WrEn), .C_Addr(C_Addr), .C_WrData(C_WrData),
        .C_Gnt(C_Gnt), .C_RdVld(C_RdVld),
        .N_Req(N_Req), .N_WrEn(N_WrEn), .N_Addr(N_Addr), .N_WrData(N_WrData),
        .N_Gnt(N_Gnt), .N_RdVld(N_RdVld),
        .Rd_Data(Rd_Data), .Mem_Addr(Mem_Addr), .Mem_WrData(Mem_WrData),
        .DmemEn(DmemEn), .DmemWrEn(DmemWrEn), .Mem_RdData(Mem_RdData)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s act=%h exp=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: 0 = nobody, 1 = C, 2 = N.
    int   m_owner = 0;
    int   m_wait  = 0;   // beats the owner kept while the other was waiting
    int   m_last  = 2;
    logic m_tag_v = 1'b0;
    int   m_tag_who = 0;
    int   m_g;
    int   c_wait = 0, n_wait = 0;

    function automatic int pick(input int owner, input int waitc, input int last,
                                input logic cr, input logic nr);
        logic xr, yr;
        if (owner == 0) begin
            if (cr && nr) return (last == 1) ? 2 : 1;
            if (cr) return 1;
            if (nr) return 2;
            return 0;
        end
        xr = (owner == 1) ? cr : nr;
        yr = (owner == 1) ? nr : cr;
        if (xr && !(yr && waitc >= HOLD_MAX - 1)) return owner;
        if (yr) return 3 - owner;
        return 0;
    endfunction

    always_comb m_g = pick(m_owner, m_wait, m_last, C_Req, N_Req);

    always @(posedge Clock) begin
        if (Reset) begin
            m_owner <= 0; m_wait <= 0; m_last <= 2; m_tag_v <= 1'b0; m_tag_who <= 0;
        end else begin
            m_tag_v   <= (m_g == 1 && !C_WrEn) || (m_g == 2 && !N_WrEn);
            m_tag_who <= m_g;
            if (m_g == 0) begin
                if (m_owner != 0) m_last <= m_owner;
                m_owner <= 0;
                m_wait  <= 0;
            end else if (m_g == m_owner) begin
                m_wait <= ((m_g == 1) ? N_Req : C_Req) ? m_wait + 1 : 0;
            end else begin
                if (m_owner != 0) m_last <= m_owner;
                m_owner <= m_g;
                m_wait  <= 0;
            end
        end
        c_wait <= (Reset || !C_Req || C_Gnt) ? 0 : c_wait + 1;
        n_wait <= (Reset || !N_Req || N_Gnt) ? 0 : n_wait + 1;
    end

    // Compare process: every output, every cycle, against the model.
    always @(negedge Clock) begin
        logic ec, en, ewe;
        logic [7:0] ea;
        logic [63:0] ewd, erd;
        ec  = !Reset && m_g == 1;
        en  = !Reset && m_g == 2;
        ewe = ec ? C_WrEn : (en ? N_WrEn : 1'b0);
        ea  = ec ? C_Addr : (en ? N_Addr : 8'h00);
        ewd = ec ? C_WrData : (en ? N_WrData : 64'h0);
        erd = (!Reset && m_tag_v) ? Mem_RdData : 64'h0;
        chk("c_gnt", 64'(C_Gnt), 64'(ec));
        chk("n_gnt", 64'(N_Gnt), 64'(en));
        chk("dmem_en", 64'(DmemEn), 64'(ec | en));
        chk("dmem_wren", 64'(DmemWrEn), 64'(ewe));
        chk("mem_addr", 64'(Mem_Addr), 64'(ea));
        chk("mem_wrdata", Mem_WrData, ewd);
        chk("c_rdvld", 64'(C_RdVld), 64'(!Reset && m_tag_v && m_tag_who == 1));
        chk("n_rdvld", 64'(N_RdVld), 64'(!Reset && m_tag_v && m_tag_who == 2));
        chk("rd_data", Rd_Data, erd);
        if (!Reset && C_Req) chk("c_starve", 64'(c_wait >= HOLD_MAX && !C_Gnt), 64'(0));
        if (!Reset && N_Req) chk("n_starve", 64'(n_wait >= HOLD_MAX && !N_Gnt), 64'(0));
    end

    task automatic tick();
        @(posedge Clock);
        #1;
        Mem_RdData = {$urandom, $urandom};
    endtask

    task automatic setc(input logic r, input logic w, input logic [7:0] a, input logic [63:0] d);
        C_Req = r; C_WrEn = w; C_Addr = a; C_WrData = d;
    endtask

    task automatic setn(input logic r, input logic w, input logic [7:0] a, input logic [63:0] d);
        N_Req = r; N_WrEn = w; N_Addr = a; N_WrData = d;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        setc(0, 0, 8'h00, 64'h0);
        setn(0, 0, 8'h00, 64'h0);
        tick();
        tick();
        Reset = 1'b0;
    endtask

    logic [8:0] pat;
    logic cg, ng;
    int rate;

    initial begin
        Reset = 1'b1;
        Mem_RdData = 64'h0;
        setc(0, 0, 8'h00, 64'h0);
        setn(0, 0, 8'h00, 64'h0);
        tick();
        @(negedge Clock);
        chk("rst_dmem_en", 64'(DmemEn), 64'(0));
        chk("rst_rd_data", Rd_Data, 64'h0);
        do_reset();

        // Core read at 0x10, data back next cycle.
        setc(1, 0, 8'h10, 64'h0);
        @(negedge Clock);
        chk("t1_c_gnt", 64'(C_Gnt), 64'(1));
        chk("t1_wren", 64'(DmemWrEn), 64'(0));
        chk("t1_addr", 64'(Mem_Addr), 64'h10);
        tick();
        setc(0, 0, 8'h00, 64'h0);
        @(negedge Clock);
        chk("t1_c_rdvld", 64'(C_RdVld), 64'(1));
        chk("t1_n_rdvld", 64'(N_RdVld), 64'(0));
        chk("t1_rd_data", Rd_Data, Mem_RdData);
        tick();

        // Both held from reset: C x4, N x4, C.
        do_reset();
        setc(1, 1, 8'h01, 64'h11);
        setn(1, 1, 8'h02, 64'h22);
        pat = 9'b1_0000_1111;
        for (int i = 0; i < 9; i++) begin
            @(negedge Clock);
            chk($sformatf("t2_c_gnt%0d", i), 64'(C_Gnt), 64'(pat[i]));
            chk($sformatf("t2_n_gnt%0d", i), 64'(N_Gnt), 64'(!pat[i]));
            tick();
        end

        // N-only writes stream every cycle.
        do_reset();
        setn(1, 1, 8'hFF, 64'hDEADBEEF00000001);
        for (int i = 0; i < 10; i++) begin
            @(negedge Clock);
            chk("t3_n_gnt", 64'(N_Gnt), 64'(1));
            chk("t3_wren", 64'(DmemWrEn), 64'(1));
            chk("t3_wrdata", Mem_WrData, 64'hDEADBEEF00000001);
            chk("t3_rdvld", 64'(C_RdVld | N_RdVld), 64'(0));
            tick();
        end

        // C owns, drops; N takes over the same cycle and then owns.
        do_reset();
        setc(1, 1, 8'h03, 64'h33);
        tick();
        tick();
        setc(0, 0, 8'h00, 64'h0);
        setn(1, 1, 8'h04, 64'h44);
        @(negedge Clock);
        chk("t4_n_gnt", 64'(N_Gnt), 64'(1));
        tick();
        setc(1, 1, 8'h05, 64'h55);
        @(negedge Clock);
        chk("t4_n_own", 64'(N_Gnt), 64'(1));
        tick();

        // N read then C read: returns in grant order.
        setc(0, 0, 8'h00, 64'h0);
        setn(0, 0, 8'h00, 64'h0);
        tick();
        setn(1, 0, 8'h06, 64'h0);
        @(negedge Clock);
        chk("t5_n_gnt", 64'(N_Gnt), 64'(1));
        tick();
        setn(0, 0, 8'h00, 64'h0);
        setc(1, 0, 8'h07, 64'h0);
        @(negedge Clock);
        chk("t5_c_gnt", 64'(C_Gnt), 64'(1));
        chk("t5_n_rdvld", 64'(N_RdVld), 64'(1));
        chk("t5_rd_data_n", Rd_Data, Mem_RdData);
        tick();
        setc(0, 0, 8'h00, 64'h0);
        @(negedge Clock);
        chk("t5_c_rdvld", 64'(C_RdVld), 64'(1));
        chk("t5_n_rdvld2", 64'(N_RdVld), 64'(0));
        tick();

        // N read, then reset with both requesting: return dropped, C wins after.
        setn(1, 0, 8'h08, 64'h0);
        @(negedge Clock);
        chk("t6_n_gnt", 64'(N_Gnt), 64'(1));
        tick();
        Reset = 1'b1;
        setc(1, 0, 8'h09, 64'h0);
        @(negedge Clock);
        chk("t6_n_rdvld", 64'(N_RdVld), 64'(0));
        chk("t6_gnts", 64'({C_Gnt, N_Gnt, DmemEn}), 64'(0));
        chk("t6_rd_data", Rd_Data, 64'h0);
        tick();
        Reset = 1'b0;
        @(negedge Clock);
        chk("t6_first_tie", 64'({C_Gnt, N_Gnt}), 64'(2'b10));
        tick();

        // Random phase; requesters hold until granted.
        for (int ph = 0; ph < 3; ph++) begin
            rate = (ph == 0) ? 30 : ((ph == 1) ? 70 : 95);
            for (int i = 0; i < 1500; i++) begin
                @(negedge Clock);
                cg = C_Gnt;
                ng = N_Gnt;
                tick();
                Reset = ($urandom_range(0, 299) == 0);
                if (!C_Req || cg)
                    setc(32'($urandom_range(0, 99)) < 32'(rate), 1'($urandom),
                         8'($urandom), {$urandom, $urandom});
                if (!N_Req || ng)
                    setn(32'($urandom_range(0, 99)) < 32'(rate), 1'($urandom),
                         8'($urandom), {$urandom, $urandom});
            end
        end
        Reset = 1'b0;
        @(negedge Clock);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single data-memory port (8-bit address, 64-bit data, one-cycle read latency) between two requesters.
- Requester C is the processor core load/store port; requester N is the network-interface/DMA port.
- Sits between the core's Dmem pins and the physical Dmem.
- Arbitrates per beat with ownership and a starvation bound, and steers read data back to the requester that issued the read.

Parameters:
ADDR_W, 8, memory address width
DATA_W, 64, memory data width
HOLD_MAX, 4, max consecutive beats an owner keeps the port while the other requester waits (>=1)

Ports:
Clock  input  1  clock
Reset  input  1  synchronous active-high reset
C_Req  input  1  core requests one beat this cycle
C_WrEn  input  1  core beat is a write (1) or read (0)
C_Addr  input  ADDR_W  core address
C_WrData  input  DATA_W  core write data
C_Gnt  output  1  core beat accepted this cycle
C_RdVld  output  1  read data for core valid on Rd_Data
N_Req  input  1  NIC requests one beat
N_WrEn  input  1  NIC write/read
N_Addr  input  ADDR_W  NIC address
N_WrData  input  DATA_W  NIC write data
N_Gnt  output  1  NIC beat accepted
N_RdVld  output  1  read data for NIC valid on Rd_Data
Rd_Data  output  DATA_W  read data returned to both requesters
Mem_Addr  output  ADDR_W  to Dmem
Mem_WrData  output  DATA_W  to Dmem
DmemEn  output  1  Dmem enable
DmemWrEn  output  1  Dmem write enable
Mem_RdData  input  DATA_W  Dmem read data, valid the cycle after a read enable

Behaviour:
- Clock is Clock; reset is Reset, synchronous, active-high.
- Reset state: FSM=IDLE, hold counter=0, last_owner=N (C wins the first tie).
- All outputs are 0 during and after reset until a request arrives.
- Any in-flight read return is dropped: RdVld is 0 the cycle after reset.
- Handshake:
  - Req/WrEn/Addr/WrData are sampled in the same cycle.
  - Gnt is combinational in the same cycle.
  - A beat completes when Req&Gnt; no retry state is kept.
  - A requester that is not granted holds its request until granted.
- Memory mux is combinational from the granted requester:
  - DmemEn = C_Gnt|N_Gnt.
  - DmemWrEn = granted WrEn.
  - Mem_Addr and Mem_WrData come from the granted requester.
  - With no grant, Mem_Addr and Mem_WrData = 0.
- At most one Gnt is high per cycle.
- FSM states are IDLE, C_OWN, N_OWN.
- IDLE:
  - Only C_Req: grant C, go to C_OWN.
  - Only N_Req: grant N, go to N_OWN.
  - Both: grant the requester not equal to last_owner, go to its OWN state.
  - Neither: stay.
- X_OWN (X owner, Y other):
  - X_Req and (!Y_Req or cnt<HOLD_MAX-1): grant X. Cnt increments only while Y_Req=1, saturating; cnt clears when Y_Req=0.
  - X_Req and Y_Req and cnt==HOLD_MAX-1: grant Y, go to Y_OWN, cnt=0, last_owner=X.
  - !X_Req and Y_Req: grant Y the same cycle, go to Y_OWN, cnt=0.
  - Neither: no grant, go to IDLE, last_owner=X.
- Entering any OWN state from IDLE clears cnt.
- Read return:
  - A 1-deep tag register records {valid, who} for each granted read.
  - The next cycle, Rd_Data = Mem_RdData and the matching RdVld=1 for exactly one cycle.
  - Writes generate no RdVld.
  - Back-to-back reads pipeline at one per cycle; a tag is overwritten each cycle.
- Same-cycle read by one requester and write by the other is impossible (single grant). Ordering is the grant order.
- Starvation bound: a waiting requester is granted within HOLD_MAX cycles of asserting Req.
- Reset mid-read: tag cleared, no RdVld, FSM to IDLE regardless of Req levels.

Test Plan:
- Reset, then C_Req=1 read Addr=0x10 -> C_Gnt=1, DmemEn=1, DmemWrEn=0, Mem_Addr=0x10 same cycle; next cycle C_RdVld=1, N_RdVld=0, Rd_Data=Mem_RdData.
- Both request from IDLE after reset -> C granted first (last_owner=N). Both held continuously with HOLD_MAX=4 -> grants C,C,C,C,N,N,N,N,C,... and never two Gnt in one cycle.
- Only N_Req=1 write Addr=0xFF, WrData=0xDEADBEEF00000001 for 10 cycles -> N_Gnt every cycle, DmemWrEn=1, no RdVld, cnt stays 0.
- C owns; C drops Req while N_Req=1 -> N_Gnt the same cycle; FSM N_OWN; cnt=0.
- N read granted at cycle t, C read granted at t+1 -> N_RdVld at t+1, C_RdVld at t+2, each for one cycle with the respective Mem_RdData.
- N read granted, Reset asserted the next cycle -> N_RdVld stays 0, all outputs 0, and the first post-reset tie goes to C.
